operand_fetch_stage: RTL and testbench
======================================

# operand_fetch_stage

Registered, parametrised operand-fetch pipeline stage placed between instruction fetch and execute. It decodes the 32-bit instruction and reads two source operands from an integrated register file, with same-cycle writeback bypass. It also produces the extended immediate and the branch target. Results are held in an output pipeline register governed by valid/ready handshakes, a flush, and an illegal-encoding flag.

## Interface
- `XLEN`, 32: data/PC width; ≥ 32.
- `NREGS`, 16: architectural registers; power of two, ≤ 16 (4-bit fields).
- `RA_IDX`, 15: register read as op1 when `isret`.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: instruction/PC/flags valid.
- `in_ready` out 1: stage accepts input this cycle.
- `instruction` in 32: encoded instruction.
- `pc_current` in XLEN: PC of the instruction.
- `isret`, `isst` in 1: operand-select controls from control unit, sampled with `in_valid`.
- `flush` in 1: kill the held and incoming instruction.
- `wb_en` in 1, `wb_addr` in 4, `wb_data` in XLEN: register-file write port.
- `out_valid` out 1; `out_ready` in 1: downstream handshake.
- `opcode` out 5, `I` out 1, `rd` out 4: decoded fields.
- `immx`, `branchtarget`, `op1`, `op2` out XLEN: operands.
- `illegal` out 1: reserved immediate modifier seen.

## Operation
- Fields:
  - `opcode`=[31:27], `I`=[26], `rd`=[25:22], rs1=[21:18], rs2=[17:14], mod=[17:16], imm16=[15:0], off27=[26:0].
- Read addresses:
  - a1 = `isret` ? `RA_IDX` : rs1.
  - a2 = `isst` ? [25:22] : rs2.
  - Addresses ≥ `NREGS` read 0.
- Bypass: if `wb_en` and `wb_addr`==a1 (a2), op1 (op2) takes `wb_data` the same cycle, not the stale register value.
- Immediate, when `I`=1:
  - mod 00: sign-extend imm16 to XLEN.
  - mod 01: zero-extend imm16.
  - mod 10: imm16 << 16, zero-extended.
  - mod 11: `immx`=0 and `illegal`=1.
- When `I`=0: `immx`=0 and `illegal`=0.
- Branch target:
  - `branchtarget` = `pc_current` + sign-extend({off27,2'b00}) to XLEN.
  - Modulo 2^XLEN; wrap-around silently permitted.
- Register file:
  - Write on `clk` when `wb_en` and `wb_addr` < `NREGS`.
  - Writes occur independently of handshake, stall and flush.
- Handshake:
  - `in_ready` = !`out_valid` || `out_ready`.
  - Transfer in when `in_valid` && `in_ready` && !`flush`.
  - Transfer out when `out_valid` && `out_ready`.
  - While stalled (`out_valid` && !`out_ready`), all outputs are held stable.
- Flush: next cycle `out_valid`=0. Any simultaneous input is dropped; the held instruction is discarded.

## Timing
- Latency: 1 cycle, input accept to `out_valid`. Full throughput: one instruction per cycle when `out_ready` is held high.
- Operands are captured at accept. A write to a source register one cycle after accept is **not** reflected in the held `op1`/`op2`; the hazard unit handles that case.
- Reset (async assert, sync release):
  - `out_valid`=0, `illegal`=0.
  - All data outputs = 0.
  - All registers = 0.
- Reset mid-stall drops the held instruction.
- Simultaneous `flush` and `out_ready`: flush wins; nothing is accepted that cycle.
- Simultaneous write to and read of the same register in the accept cycle: the bypass value is captured.

## Structure
- Shared package `cpu_pkg`:
  - Opcode width (5), register address width (4), field bit positions.
  - Immediate-modifier enum {IMM_S, IMM_U, IMM_H, IMM_RSV}.
  - `RA_IDX` default.
- Sub-module `reg_file`:
  - `NREGS`×XLEN storage, two combinational read ports, one write port, async active-low clear.
  - Bypass muxing lives in `operand_fetch_stage`, not in `reg_file`.

## Test plan
- Sign-extended immediate: instr `I`=1, mod 00, imm16=0xFFF0 → `immx`=0xFFFFFFF0 one cycle after accept, `illegal`=0. Then mod 10, imm16=0x1234 → `immx`=0x12340000.
- Branch target: pc=0x100, off27=0x7FFFFFF (−1) → `branchtarget`=0x000000FC. pc=0xFFFFFFFC, off27=1 → 0x00000000 (wrap).
- Operand selection: write r15=0xAA, r3=0x33, r5=0x55. `isret`=1, rs1=3 → `op1`=0xAA. `isst`=1, [25:22]=5, rs2=3 → `op2`=0x55.
- Bypass: r7=0x1 held; accept rs1=7 while `wb_en`=1, `wb_addr`=7, `wb_data`=0x99 → `op1`=0x99.
- Backpressure: `out_ready`=0 for 3 cycles with `in_valid`=1 → `in_ready`=0 and outputs stable. Release → the next instruction appears the following cycle, none lost or duplicated.
- Flush and reset:
  - `flush` during a stall → `out_valid`=0 next cycle.
  - Assert `rst_n`=0 mid-stream → `out_valid`=0 immediately and all registers read 0 after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared field layout, immediate modifiers and defaults for the cpu pipeline
package cpu_pkg;
  localparam int OPC_W = 5;
  localparam int REG_W = 4;
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;
  localparam int I_BIT = 26;
  localparam int RD_HI = 25;
  localparam int RD_LO = 22;
  localparam int RS1_HI = 21;
  localparam int RS1_LO = 18;
  localparam int RS2_HI = 17;
  localparam int RS2_LO = 14;
  localparam int MOD_HI = 17;
  localparam int MOD_LO = 16;
  localparam int IMM_W = 16;
  localparam int OFF_W = 27;
  localparam int RA_IDX_DEF = 15;
  typedef enum logic [1:0] {IMM_S, IMM_U, IMM_H, IMM_RSV} imm_mod_e;
endpackage

// File: rtl/operand_fetch_stage_reg_file.sv
// reg_file: NREGS x XLEN register file, two combinational reads, one write, async clear
module reg_file
  import cpu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREGS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [REG_W-1:0] waddr,
  input  logic [XLEN-1:0]  wdata,
  input  logic [REG_W-1:0] raddr1,
  input  logic [REG_W-1:0] raddr2,
  output logic [XLEN-1:0]  rdata1,
  output logic [XLEN-1:0]  rdata2
);
  localparam int AW = NREGS > 1 ? $clog2(NREGS) : 1;
  logic [XLEN-1:0] regs [NREGS];
  function automatic logic in_range(input logic [REG_W-1:0] a);
    return int'(a) < NREGS;
  endfunction
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    else if (we && in_range(waddr))
      regs[waddr[AW-1:0]] <= wdata;
  assign rdata1 = in_range(raddr1) ? regs[raddr1[AW-1:0]] : '0;
  assign rdata2 = in_range(raddr2) ? regs[raddr2[AW-1:0]] : '0;
endmodule

// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: decode, operand read with writeback bypass, registered handshake output
module operand_fetch_stage
  import cpu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREGS = 16,
  parameter int RA_IDX = RA_IDX_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instruction,
  input  logic [XLEN-1:0]  pc_current,
  input  logic             isret,
  input  logic             isst,
  input  logic             flush,
  input  logic             wb_en,
  input  logic [REG_W-1:0] wb_addr,
  input  logic [XLEN-1:0]  wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OPC_W-1:0] opcode,
  output logic             I,
  output logic [REG_W-1:0] rd,
  output logic [XLEN-1:0]  immx,
  output logic [XLEN-1:0]  branchtarget,
  output logic [XLEN-1:0]  op1,
  output logic [XLEN-1:0]  op2,
  output logic             illegal
);
  logic [REG_W-1:0] a1, a2;
  logic [XLEN-1:0]  rf1, rf2, op1_n, op2_n, imm_n, bt_n;
  logic [IMM_W-1:0] imm16;
  logic             imm_on, ill_n, accept;
  imm_mod_e         mode;
  reg_file #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
    .clk(clk), .rst_n(rst_n), .we(wb_en), .waddr(wb_addr), .wdata(wb_data),
    .raddr1(a1), .raddr2(a2), .rdata1(rf1), .rdata2(rf2)
  );
  always_comb begin
    a1 = isret ? REG_W'(RA_IDX) : instruction[RS1_HI:RS1_LO];
    a2 = isst ? instruction[RD_HI:RD_LO] : instruction[RS2_HI:RS2_LO];
    op1_n = wb_en && wb_addr == a1 ? wb_data : rf1;
    op2_n = wb_en && wb_addr == a2 ? wb_data : rf2;
    imm16 = instruction[IMM_W-1:0];
    imm_on = instruction[I_BIT];
    mode = imm_mod_e'(instruction[MOD_HI:MOD_LO]);
    imm_n = !imm_on ? '0
          : mode == IMM_S ? {{(XLEN-IMM_W){imm16[IMM_W-1]}}, imm16}
          : mode == IMM_U ? XLEN'(imm16)
          : mode == IMM_H ? XLEN'({imm16, {IMM_W{1'b0}}})
          : '0;
    ill_n = imm_on && mode == IMM_RSV;
    bt_n = pc_current + {{(XLEN-OFF_W-2){instruction[OFF_W-1]}}, instruction[OFF_W-1:0], 2'b00};
    in_ready = !out_valid || out_ready;
    accept = in_valid && in_ready && !flush;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      opcode <= '0;
      I <= 1'b0;
      rd <= '0;
      immx <= '0;
      branchtarget <= '0;
      op1 <= '0;
      op2 <= '0;
      illegal <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      opcode <= instruction[OPC_HI:OPC_LO];
      I <= imm_on;
      rd <= instruction[RD_HI:RD_LO];
      immx <= imm_n;
      branchtarget <= bt_n;
      op1 <= op1_n;
      op2 <= op2_n;
      illegal <= ill_n;
    end else if (flush || in_ready)
      out_valid <= 1'b0;
endmodule

// File: tb/tb_operand_fetch_stage.sv
// tb_operand_fetch_stage: directed vectors, per-cycle model comparison plus literal expectations
module tb_operand_fetch_stage;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_ready, isret = 0, isst = 0, flush = 0;
  logic [31:0] instruction = 0, pc_current = 0;
  logic wb_en = 0;
  logic [3:0] wb_addr = 0;
  logic [31:0] wb_data = 0;
  logic out_valid, out_ready = 1, I, illegal;
  logic [4:0] opcode;
  logic [3:0] rd;
  logic [31:0] immx, branchtarget, op1, op2;
  int pass_cnt = 0, total_cnt = 0;

  operand_fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .pc_current(pc_current), .isret(isret), .isst(isst),
    .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .opcode(opcode), .I(I), .rd(rd),
    .immx(immx), .branchtarget(branchtarget), .op1(op1), .op2(op2), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", n, act, exp);
    else pass_cnt++;
  endtask

  // Reference model: architectural register array plus one held result slot
  logic [31:0] mregs [16];
  logic m_valid, m_i, m_ill;
  logic [4:0] m_opcode;
  logic [3:0] m_rd;
  logic [31:0] m_immx, m_bt, m_op1, m_op2;

  function automatic logic [31:0] exp_imm(input logic [31:0] ins);
    logic [15:0] v = ins[15:0];
    if (!ins[26]) return 0;
    case (ins[17:16])
      2'd0: return 32'($signed(v));
      2'd1: return {16'h0, v};
      2'd2: return 32'(v) * 32'h10000;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] exp_bt(input logic [31:0] ins, input logic [31:0] pc);
    logic signed [31:0] s = {ins[26:0], 5'b0};
    return pc + 32'(s >>> 3);
  endfunction

  function automatic logic [31:0] rd_op(input logic [3:0] a);
    return (wb_en && wb_addr == a) ? wb_data : mregs[a];
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_valid <= 0; m_i <= 0; m_ill <= 0; m_opcode <= 0; m_rd <= 0;
      m_immx <= 0; m_bt <= 0; m_op1 <= 0; m_op2 <= 0;
      for (int i = 0; i < 16; i++) mregs[i] <= 0;
    end else begin
      if (in_valid && (!m_valid || out_ready) && !flush) begin
        m_valid <= 1;
        m_opcode <= instruction[31:27];
        m_i <= instruction[26];
        m_rd <= instruction[25:22];
        m_immx <= exp_imm(instruction);
        m_ill <= instruction[26] && instruction[17:16] == 2'd3;
        m_bt <= exp_bt(instruction, pc_current);
        m_op1 <= rd_op(isret ? 4'd15 : instruction[21:18]);
        m_op2 <= rd_op(isst ? instruction[25:22] : instruction[17:14]);
      end else if (flush || out_ready) m_valid <= 0;
      if (wb_en) mregs[wb_addr] <= wb_data;
    end

  always @(negedge clk) begin
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
    if (m_valid) begin
      chk("opcode", 32'(opcode), 32'(m_opcode));
      chk("I", 32'(I), 32'(m_i));
      chk("rd", 32'(rd), 32'(m_rd));
      chk("immx", immx, m_immx);
      chk("branchtarget", branchtarget, m_bt);
      chk("op1", op1, m_op1);
      chk("op2", op2, m_op2);
      chk("illegal", 32'(illegal), 32'(m_ill));
    end
  end

  function automatic logic [31:0] mk(input logic [4:0] op, input logic i, input logic [3:0] r,
                                     input logic [3:0] s1, input logic [17:0] low);
    return {op, i, r, s1, low};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    wb_en = 1; wb_addr = a; wb_data = d;
    step();
    wb_en = 0;
  endtask

  initial begin
    repeat (2) step();
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst op1", op1, 0);
    chk("rst immx", immx, 0);
    rst_n = 1;
    wr(15, 32'hAA); wr(3, 32'h33); wr(5, 32'h55); wr(7, 32'h1);
    in_valid = 1;
    instruction = mk(5'd1, 1, 4'd2, 4'd0, {2'b00, 16'hFFF0});
    step();
    chk("sext immx", immx, 32'hFFFFFFF0);
    chk("sext illegal", 32'(illegal), 0);
    chk("sext valid", 32'(out_valid), 1);
    instruction = mk(5'd1, 1, 4'd2, 4'd0, {2'b10, 16'h1234});
    step();
    chk("hi immx", immx, 32'h12340000);
    instruction = mk(5'd1, 1, 4'd2, 4'd0, {2'b01, 16'h8001});
    step();
    chk("zext immx", immx, 32'h00008001);
    instruction = mk(5'd1, 1, 4'd2, 4'd0, {2'b11, 16'hBEEF});
    step();
    chk("rsv immx", immx, 0);
    chk("rsv illegal", 32'(illegal), 1);
    instruction = {5'd3, 27'h7FFFFFF}; pc_current = 32'h100;
    step();
    chk("bt back", branchtarget, 32'hFC);
    instruction = {5'd3, 27'd1}; pc_current = 32'hFFFFFFFC;
    step();
    chk("bt wrap", branchtarget, 32'h0);
    instruction = mk(5'd0, 0, 4'd5, 4'd3, {4'd3, 14'd0}); isret = 1; isst = 1;
    step();
    chk("isret op1", op1, 32'hAA);
    chk("isst op2", op2, 32'h55);
    isret = 0; isst = 0;
    step();
    chk("rs1 op1", op1, 32'h33);
    chk("rs2 op2", op2, 32'h33);
    instruction = mk(5'd0, 0, 4'd1, 4'd7, 18'd0);
    wb_en = 1; wb_addr = 7; wb_data = 32'h99;
    step();
    wb_en = 0;
    chk("bypass op1", op1, 32'h99);
    step();
    chk("written op1", op1, 32'h99);
    instruction = mk(5'd2, 1, 4'd0, 4'd0, {2'b01, 16'h0011});
    step();
    chk("A immx", immx, 32'h11);
    out_ready = 0;
    instruction = mk(5'd2, 1, 4'd0, 4'd0, {2'b01, 16'h0022});
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall in_ready", 32'(in_ready), 0);
      chk("stall immx", immx, 32'h11);
    end
    out_ready = 1;
    step();
    chk("B immx", immx, 32'h22);
    in_valid = 0;
    step();
    chk("B drained", 32'(out_valid), 0);
    in_valid = 1;
    step();
    out_ready = 0; flush = 1;
    step();
    chk("flush stall", 32'(out_valid), 0);
    flush = 0; out_ready = 1;
    step();
    flush = 1;
    step();
    chk("flush ready", 32'(out_valid), 0);
    flush = 0;
    step();
    out_ready = 0;
    step();
    #2 rst_n = 0;
    #1 chk("async rst", 32'(out_valid), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1; out_ready = 1;
    instruction = mk(5'd0, 0, 4'd5, 4'd3, {4'd3, 14'd0}); isret = 1; isst = 1;
    step();
    chk("post rst op1", op1, 0);
    chk("post rst op2", op2, 0);
    isret = 0; isst = 0;
    step();
    chk("post rst r3", op1, 0);
    in_valid = 0;
    repeat (2) step();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
